aurora_cmd_wbmaster: RTL and testbench

- Consumes the split command streams produced by the Aurora command generator and executes them as Wishbone classic bus cycles.
  - Address stream: bit 31 = 1 is a read, 0 is a write.
  - Data stream: write data only.
- Returns read data as a single-word AXI4-Stream response.
- Sits between the command generator and the TURFIO register Wishbone interconnect.
- A read is issued only when the response slot is free, so a stalled response path never deadlocks the bus.

---
 rtl/aurora_cmd_wbmaster.sv | 139 +++++++++++++
 tb/tb_aurora_cmd_wbmaster.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_cmd_wbmaster.sv
// Executes Aurora address/data command streams as Wishbone classic cycles.
// Read data comes back as a single-word AXI4-Stream response.
module aurora_cmd_wbmaster #(
  parameter int          ADDR_BITS = 22,
  parameter int          TIMEOUT   = 1024,
  parameter logic [31:0] ERR_VALUE = 32'hFFFFFFFF
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [31:0]          s_cmd_addr_tdata,
  input  logic                 s_cmd_addr_tvalid,
  output logic                 s_cmd_addr_tready,
  input  logic [31:0]          s_cmd_data_tdata,
  input  logic                 s_cmd_data_tvalid,
  output logic                 s_cmd_data_tready,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic                 wb_we_o,
  output logic [ADDR_BITS-1:0] wb_adr_o,
  output logic [31:0]          wb_dat_o,
  output logic [3:0]           wb_sel_o,
  input  logic [31:0]          wb_dat_i,
  input  logic                 wb_ack_i,
  input  logic                 wb_err_i,
  output logic [31:0]          m_resp_tdata,
  output logic                 m_resp_tvalid,
  input  logic                 m_resp_tready,
  output logic [15:0]          err_count
);

  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             is_read_s;
  logic             addr_ready_s;
  logic             data_ready_s;
  logic             fail_s;
  logic             done_s;
  logic             unused_addr_s;

  assign is_read_s     = s_cmd_addr_tdata[31];
  assign unused_addr_s = ^s_cmd_addr_tdata;
  assign wb_sel_o      = 4'hF;

  assign s_cmd_addr_tready = addr_ready_s;
  assign s_cmd_data_tready = data_ready_s;

  // Accept a command only from IDLE; writes pop both streams together, reads need a free response slot.
  always_comb begin
    addr_ready_s = 1'b0;
    data_ready_s = 1'b0;
    if (aresetn && (state_r == ST_IDLE) && s_cmd_addr_tvalid) begin
      if (is_read_s) begin
        addr_ready_s = !m_resp_tvalid;
      end else begin
        addr_ready_s = s_cmd_data_tvalid;
        data_ready_s = s_cmd_data_tvalid;
      end
    end else begin
      addr_ready_s = 1'b0;
      data_ready_s = 1'b0;
    end
  end

  // Bus termination: err beats ack, and ack beats a same-cycle timeout.
  always_comb begin
    fail_s = wb_err_i || (!wb_ack_i && (cnt_r == CNT_LAST));
    done_s = wb_ack_i || fail_s;
  end

  // Command FSM, Wishbone master outputs, response slot and error counter.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r       <= ST_IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
      wb_we_o       <= 1'b0;
      wb_adr_o      <= {ADDR_BITS{1'b0}};
      wb_dat_o      <= 32'd0;
      m_resp_tvalid <= 1'b0;
      m_resp_tdata  <= 32'd0;
      err_count     <= 16'd0;
    end else begin
      if (m_resp_tvalid && m_resp_tready) begin
        m_resp_tvalid <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (addr_ready_s) begin
            wb_adr_o <= s_cmd_addr_tdata[ADDR_BITS-1:0];
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            cnt_r    <= {CNT_W{1'b0}};
            if (is_read_s) begin
              wb_we_o <= 1'b0;
              state_r <= ST_READ;
            end else begin
              wb_we_o  <= 1'b1;
              wb_dat_o <= s_cmd_data_tdata;
              state_r  <= ST_WRITE;
            end
          end
        end
        ST_WRITE, ST_READ: begin
          if (done_s) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            state_r  <= ST_IDLE;
            // The slot is guaranteed empty here: reads only start when tvalid is low.
            if (state_r == ST_READ) begin
              m_resp_tvalid <= 1'b1;
              m_resp_tdata  <= fail_s ? ERR_VALUE : wb_dat_i;
            end
            if (fail_s && (err_count != 16'hFFFF)) begin
              err_count <= err_count + 16'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aurora_cmd_wbmaster.sv
// Randomized scoreboard bench for aurora_cmd_wbmaster with a behavioural slave model.
module tb_aurora_cmd_wbmaster;
  localparam int AB = 22;
  localparam int TO = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [31:0]   s_cmd_addr_tdata = 32'd0;
  logic          s_cmd_addr_tvalid = 1'b0;
  logic          s_cmd_addr_tready;
  logic [31:0]   s_cmd_data_tdata = 32'd0;
  logic          s_cmd_data_tvalid = 1'b0;
  logic          s_cmd_data_tready;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AB-1:0] wb_adr_o;
  logic [31:0]   wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic [31:0]   wb_dat_i = 32'd0;
  logic          wb_ack_i = 1'b0;
  logic          wb_err_i = 1'b0;
  logic [31:0]   m_resp_tdata;
  logic          m_resp_tvalid;
  logic          m_resp_tready = 1'b1;
  logic [15:0]   err_count;

  aurora_cmd_wbmaster #(.ADDR_BITS(AB), .TIMEOUT(TO), .ERR_VALUE(32'hFFFFFFFF)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_cmd_addr_tdata(s_cmd_addr_tdata), .s_cmd_addr_tvalid(s_cmd_addr_tvalid),
    .s_cmd_addr_tready(s_cmd_addr_tready),
    .s_cmd_data_tdata(s_cmd_data_tdata), .s_cmd_data_tvalid(s_cmd_data_tvalid),
    .s_cmd_data_tready(s_cmd_data_tready),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .m_resp_tdata(m_resp_tdata), .m_resp_tvalid(m_resp_tvalid), .m_resp_tready(m_resp_tready),
    .err_count(err_count)
  );

  always #5 aclk = ~aclk;

  // mode: 0 ack, 1 err, 2 silent slave, 3 ack and err together
  typedef struct {
    bit          we;
    logic [AB-1:0] adr;
    logic [31:0] dat;
    int          dur;
    int          waits;
    int          mode;
    bit          is_err;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] resp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          pending = 0;
  int          done_err = 0;
  bit          in_rst = 1'b0;
  int          rdy_mode = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Response-ready pattern: always, random, or held off.
  always @(posedge aclk) begin
    #2;
    case (rdy_mode)
      0:       m_resp_tready = 1'b1;
      1:       m_resp_tready = ($urandom_range(0, 2) != 0);
      default: m_resp_tready = 1'b0;
    endcase
  end

  // Wishbone slave model and bus-cycle monitor.
  initial begin : slave
    bus_t cur;
    int   cyc_n;
    cyc_n = 0;
    cur = '{we: 1'b0, adr: '0, dat: 32'd0, dur: 0, waits: 0, mode: 2, is_err: 1'b0};
    forever begin
      @(posedge aclk);
      #1;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      if (in_rst) begin
        cyc_n = 0;
      end else if (wb_cyc_o) begin
        if (cyc_n == 0) begin
          if (bus_q.size() == 0) begin
            chk("unexpected_cyc", 32'd1, 32'd0);
            cur = '{we: 1'b0, adr: '0, dat: 32'd0, dur: 0, waits: 0, mode: 2, is_err: 1'b0};
          end else begin
            cur = bus_q.pop_front();
          end
          chk("we", 32'(wb_we_o), 32'(cur.we));
          chk("adr", 32'(wb_adr_o), 32'(cur.adr));
          if (cur.we) chk("dat_o", wb_dat_o, cur.dat);
          chk("stb", 32'(wb_stb_o), 32'd1);
          chk("sel", 32'(wb_sel_o), 32'hF);
          wb_dat_i = cur.dat;
        end
        cyc_n++;
        if (cyc_n == cur.waits + 1) begin
          case (cur.mode)
            0:       wb_ack_i = 1'b1;
            1:       wb_err_i = 1'b1;
            3:       begin wb_ack_i = 1'b1; wb_err_i = 1'b1; end
            default: wb_ack_i = 1'b0;
          endcase
        end
      end else if (cyc_n != 0) begin
        chk("cyc_len", 32'(cyc_n), 32'(cur.dur));
        done_err += int'(cur.is_err);
        chk("err_count", 32'(err_count), 32'(done_err));
        if (!cur.we) chk("resp_valid_after_end", 32'(m_resp_tvalid), 32'd1);
        pending--;
        cyc_n = 0;
      end
    end
  end

  // Response monitor: pops the scoreboard on each handshake, checks data holds under backpressure.
  initial begin : resp_mon
    bit          hold_v;
    logic [31:0] hold_d;
    hold_v = 1'b0;
    hold_d = 32'd0;
    forever begin
      @(negedge aclk);
      if (!in_rst && m_resp_tvalid) begin
        if (hold_v) chk("resp_hold", m_resp_tdata, hold_d);
        if (m_resp_tready) begin
          if (resp_q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
          else chk("resp_data", m_resp_tdata, resp_q.pop_front());
        end
      end
      hold_v = m_resp_tvalid && !m_resp_tready;
      hold_d = m_resp_tdata;
    end
  end

  task automatic send(input logic [31:0] addr, input logic [31:0] dat,
                      input int waits, input int mode, input int ddly);
    bus_t it;
    bit   rd;
    int   t;
    int   n;
    rd        = addr[31];
    it.we     = !rd;
    it.adr    = addr[AB-1:0];
    it.dat    = dat;
    it.waits  = waits;
    it.mode   = mode;
    t = (mode == 2) ? TO + 1 : waits + 1;
    if (t <= TO) begin
      it.dur    = t;
      it.is_err = (mode != 0);
    end else begin
      it.dur    = TO;
      it.is_err = 1'b1;
    end
    bus_q.push_back(it);
    if (rd) resp_q.push_back(it.is_err ? 32'hFFFF_FFFF : dat);
    @(negedge aclk);
    s_cmd_addr_tdata  = addr;
    s_cmd_addr_tvalid = 1'b1;
    s_cmd_data_tdata  = dat;
    s_cmd_data_tvalid = !rd && (ddly == 0);
    n = 0;
    forever begin
      #1;
      if (s_cmd_addr_tready) break;
      chk("data_tready_idle", 32'(s_cmd_data_tready), 32'd0);
      if (!rd && !s_cmd_data_tvalid && pending == 0) chk("no_cyc_without_data", 32'(wb_cyc_o), 32'd0);
      n++;
      if (n > 300) begin
        chk("addr_handshake_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge aclk);
      if (!rd && n >= ddly) s_cmd_data_tvalid = 1'b1;
    end
    if (s_cmd_addr_tready) begin
      chk("data_tready", 32'(s_cmd_data_tready), 32'(!rd));
      if (rd) chk("read_slot_free", 32'(m_resp_tvalid), 32'd0);
      pending++;
    end
    @(posedge aclk);
    #1;
    s_cmd_addr_tvalid = 1'b0;
    s_cmd_data_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((pending != 0 || resp_q.size() != 0) && n < 500) begin
      @(negedge aclk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin : main
    bit rd;
    int m, mode, waits;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_we", 32'(wb_we_o), 32'd0);
    chk("rst_adr", 32'(wb_adr_o), 32'd0);
    chk("rst_dat_o", wb_dat_o, 32'd0);
    chk("rst_tvalid", 32'(m_resp_tvalid), 32'd0);
    chk("rst_tdata", m_resp_tdata, 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    send(32'h0000_0010, 32'hA5A5_1234, 0, 0, 0);  drain();
    send(32'h8000_0020, 32'hCAFE_F00D, 3, 0, 0);  drain();
    send(32'h0000_0044, 32'h1234_5678, 0, 0, 10); drain();
    send(32'h8000_0040, 32'h1111_2222, 0, 2, 0);  drain();
    send(32'h8000_0040, 32'h3333_4444, 15, 0, 0); drain();
    send(32'h0000_0080, 32'h5555_6666, 1, 1, 0);
    send(32'h8000_0084, 32'h7777_8888, 2, 3, 0);  drain();

    rdy_mode = 2;
    send(32'h8000_0100, 32'hAAAA_0001, 0, 0, 0);
    fork
      send(32'h8000_0104, 32'hAAAA_0002, 1, 0, 0);
      begin
        repeat (20) @(posedge aclk);
        rdy_mode = 0;
      end
    join
    drain();

    rdy_mode = 1;
    repeat (150) begin
      rd = 1'($urandom_range(0, 1));
      m  = $urandom_range(0, 9);
      mode  = (m < 6) ? 0 : (m < 8) ? 1 : (m < 9) ? 2 : 3;
      waits = $urandom_range(0, 4);
      if ($urandom_range(0, 9) == 0) waits = $urandom_range(14, 17);
      send({rd, 31'($urandom)}, $urandom, waits, mode, $urandom_range(0, 2));
    end
    rdy_mode = 0;
    drain();

    send(32'h8000_0200, 32'h0BAD_0BAD, 0, 2, 0);
    repeat (5) @(negedge aclk);
    in_rst            = 1'b1;
    aresetn           = 1'b0;
    s_cmd_addr_tdata  = 32'h8000_0300;
    s_cmd_addr_tvalid = 1'b1;
    s_cmd_data_tvalid = 1'b1;
    @(posedge aclk);
    #1;
    chk("mid_rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("mid_rst_stb", 32'(wb_stb_o), 32'd0);
    chk("mid_rst_tvalid", 32'(m_resp_tvalid), 32'd0);
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
    chk("mid_rst_addr_tready", 32'(s_cmd_addr_tready), 32'd0);
    chk("mid_rst_data_tready", 32'(s_cmd_data_tready), 32'd0);
    bus_q.delete();
    resp_q.delete();
    pending  = 0;
    done_err = 0;
    s_cmd_addr_tvalid = 1'b0;
    s_cmd_data_tvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    in_rst = 1'b0;

    send(32'h0000_0123, 32'hDEAD_BEEF, 0, 0, 0);
    send(32'h8000_0123, 32'hFEED_FACE, 2, 0, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
